fft8_frame_sequencer: RTL and testbench

Streaming front/back end and scheduler for the 8-point DIT FFT core. It collects 8 complex samples from a valid/ready input stream and presents them as a parallel vector. It pulses the core's write/start inputs, waits a fixed pipeline latency, then captures the 8 results and streams them out in natural order with valid/ready/last. One frame is in flight at a time.

---
 rtl/fft8_frame_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fft8_frame_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_frame_sequencer.sv
// fft8_frame_sequencer
//   Valid/ready front and back end plus scheduler for the 8-point DIT FFT core.
//   Collects 8 complex samples into a parallel vector. Pulses core_write and
//   core_start together for one cycle, then waits CORE_LAT cycles. It then
//   captures the 8 core results and streams them out in natural order with
//   valid/ready/last. Only one frame is in flight at a time.
//   Samples are DW-bit signed-magnitude values. They pass bit-exact in both
//   directions, so negative zero survives unchanged.
//   Optional build macro FFT8_FRAME_CNT_EN adds a 16-bit frames_done output,
//   which counts completed output frames and wraps at 16'hFFFF.
module fft8_frame_sequencer #(
  parameter int DW       = 16,
  parameter int CORE_LAT = 5
) (
  input  logic            clk,
  input  logic            RST_N,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_re,
  input  logic [DW-1:0]   s_im,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_re,
  output logic [DW-1:0]   m_im,
  output logic            m_last,
  output logic            core_write,
  output logic            core_start,
  output logic [8*DW-1:0] core_in_r,
  output logic [8*DW-1:0] core_in_i,
  input  logic [8*DW-1:0] core_out_r,
  input  logic [8*DW-1:0] core_out_i,
  output logic            busy
`ifdef FFT8_FRAME_CNT_EN
  ,
  output logic [15:0]     frames_done
`endif
);

  // Cycle count, measured from FIRE, of the cycle whose ending edge captures the results.
  localparam logic [3:0] LAT = 4'(CORE_LAT);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] in_re_q  [8];
  logic [DW-1:0] in_re_d  [8];
  logic [DW-1:0] in_im_q  [8];
  logic [DW-1:0] in_im_d  [8];
  logic [DW-1:0] out_re_q [8];
  logic [DW-1:0] out_re_d [8];
  logic [DW-1:0] out_im_q [8];
  logic [DW-1:0] out_im_d [8];

  // Next-state, buffer update and handshake outputs for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first, so paths that skip an assignment hold
    //       the value instead of inferring a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    in_re_d    = in_re_q;
    in_im_d    = in_im_q;
    out_re_d   = out_re_q;
    out_im_d   = out_im_q;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    m_re       = '0;
    m_im       = '0;
    core_write = 1'b0;
    core_start = 1'b0;
    busy       = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          in_re_d[idx_q] = s_re;
          in_im_d[idx_q] = s_im;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_FIRE;
          end
        end
      end

      ST_FIRE: begin
        core_write = 1'b1;
        core_start = 1'b1;
        busy       = 1'b1;
        cnt_d      = 4'd1;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        busy = 1'b1;
        if (cnt_q == LAT) begin
          for (int k = 0; k < 8; k++) begin
            out_re_d[k] = core_out_r[k*DW +: DW];
            out_im_d[k] = core_out_i[k*DW +: DW];
          end
          cnt_d   = 4'd0;
          idx_d   = 3'd0;
          state_d = ST_UNLOAD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_UNLOAD: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = (idx_q == 3'd7);
        m_re    = out_re_q[idx_q];
        m_im    = out_im_q[idx_q];
        if (m_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
        idx_d   = 3'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Present the frozen input buffer to the core as two packed vectors.
  always_comb begin
    core_in_r = '0;
    core_in_i = '0;
    for (int k = 0; k < 8; k++) begin
      core_in_r[k*DW +: DW] = in_re_q[k];
      core_in_i[k*DW +: DW] = in_im_q[k];
    end
  end

  // State, index, latency counter and sample buffers.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_LOAD;
      idx_q    <= 3'd0;
      cnt_q    <= 4'd0;
      // NOTE: the buffers are reset, so m_re/m_im and core_in_* never show stale
      //       data after reset; being flops rather than RAM, they can be cleared.
      in_re_q  <= '{default: '0};
      in_im_q  <= '{default: '0};
      out_re_q <= '{default: '0};
      out_im_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments let every flop sample pre-edge values, so the
      //       order of these statements does not matter.
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      in_re_q  <= in_re_d;
      in_im_q  <= in_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
    end
  end

`ifdef FFT8_FRAME_CNT_EN
  logic [15:0] frames_done_q, frames_done_d;

  // Count completed output frames (the m_last handshake), wrapping naturally at 16 bits.
  always_comb begin
    frames_done_d = frames_done_q;
    if (state_q == ST_UNLOAD && m_ready && idx_q == 3'd7) begin
      frames_done_d = frames_done_q + 16'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      frames_done_q <= 16'd0;
    end else begin
      frames_done_q <= frames_done_d;
    end
  end

  assign frames_done = frames_done_q;
`endif

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Testbench for fft8_frame_sequencer (DW=16, CORE_LAT=5).
// A behavioural 8-point DFT stands in for the FFT core. It presents correct
// results only in the exact capture cycle and inverted data in every other
// cycle. Expected bins come from hand-computed tables or from the same DFT
// applied to the samples the bench sent.
module tb_fft8_frame_sequencer;

  localparam int DW  = 16;
  localparam int LAT = 5;
  localparam real PI = 3.14159265358979323846;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_valid, s_ready;
  logic [DW-1:0]  s_re, s_im;
  logic           m_valid, m_ready;
  logic [DW-1:0]  m_re, m_im;
  logic           m_last;
  logic           core_write, core_start, busy;
  logic [127:0]   core_in_r, core_in_i, core_out_r, core_out_i;
`ifdef FFT8_FRAME_CNT_EN
  logic [15:0]    frames_done;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frames   = 0;

  fft8_frame_sequencer #(.DW(DW), .CORE_LAT(LAT)) dut (
    .clk        (clk),
    .RST_N      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_re       (s_re),
    .s_im       (s_im),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_re       (m_re),
    .m_im       (m_im),
    .m_last     (m_last),
    .core_write (core_write),
    .core_start (core_start),
    .core_in_r  (core_in_r),
    .core_in_i  (core_in_i),
    .core_out_r (core_out_r),
    .core_out_i (core_out_i),
    .busy       (busy)
`ifdef FFT8_FRAME_CNT_EN
    ,
    .frames_done(frames_done)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference arithmetic ----------------
  function automatic real sm2r(input logic [15:0] v);
    real m;
    m = real'(v[14:0]) / 256.0;
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2sm(input real v);
    real a;
    int  m;
    a = (v < 0.0) ? -v : v;
    m = $rtoi(a * 256.0 + 0.5);
    if (m > 32767) m = 32767;
    return {(v < 0.0), 15'(m)};
  endfunction

  task automatic dft(input logic [127:0] xr, input logic [127:0] xi,
                     output logic [127:0] yr, output logic [127:0] yi);
    real ar, ai, a, vr, vi;
    yr = '0;
    yi = '0;
    for (int k = 0; k < 8; k++) begin
      ar = 0.0;
      ai = 0.0;
      for (int n = 0; n < 8; n++) begin
        a  = 2.0 * PI * real'(k * n) / 8.0;
        vr = sm2r(xr[16*n +: 16]);
        vi = sm2r(xi[16*n +: 16]);
        ar = ar + vr * $cos(a) + vi * $sin(a);
        ai = ai + vi * $cos(a) - vr * $sin(a);
      end
      yr[16*k +: 16] = r2sm(ar);
      yi[16*k +: 16] = r2sm(ai);
    end
  endtask

  // ---------------- FFT core model ----------------
  logic [127:0] res_r = '0, res_i = '0, tr, ti;
  int           core_c = 0;

  always @(posedge clk) begin
    if (core_write) begin
      dft(core_in_r, core_in_i, tr, ti);
      res_r  <= tr;
      res_i  <= ti;
      core_c <= 1;
    end else if (core_c != 0 && core_c < 250) begin
      core_c <= core_c + 1;
    end
  end

  always_comb begin
    core_out_r = (core_c == LAT) ? res_r : ~res_r;
    core_out_i = (core_c == LAT) ? res_i : ~res_i;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Hand-table bins: a zero magnitude may carry either sign.
  task automatic check_bin(input string name, input logic [15:0] got, input logic [15:0] exp);
    bit ok;
    checks++;
    ok = (exp[14:0] == 15'd0) ? (got[14:0] == 15'd0 && !$isunknown(got)) : (got === exp);
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Push one frame in, then drain it. Entered and left at a negedge while the DUT is in LOAD.
  task automatic run_frame(input logic [127:0] xr, input logic [127:0] xi, input bit gaps,
                           input int bp_bin, input int bp_len,
                           output logic [127:0] yr, output logic [127:0] yi);
    int          n, guard, t_last, t_first, bin, hold;
    bit          toggle, stalled, wait_bad;
    logic [32:0] prev;
    yr = '0; yi = '0; n = 0; guard = 0; toggle = 1'b0; t_last = 0;
    while (n < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (gaps && toggle) begin
        s_valid = 1'b0; s_re = 16'hdead; s_im = 16'hbeef;
      end else begin
        s_valid = 1'b1; s_re = xr[16*n +: 16]; s_im = xi[16*n +: 16];
      end
      toggle = ~toggle;
      if (s_valid && s_ready) begin
        n++;
        t_last = cyc;
      end
    end
    check("load_handshakes", n, 8);
    if (n != 8) return;

    // FIRE cycle; s_valid stays high with junk that must not be consumed.
    @(negedge clk);
    s_valid = 1'b1; s_re = 16'hffff; s_im = 16'h8000;
    check("fire_ctrl", {core_write, core_start, s_ready, busy}, 4'b1101);
    check("fire_core_in_r", core_in_r, xr);
    check("fire_core_in_i", core_in_i, xi);

    t_first = -1; wait_bad = 1'b0;
    for (int c = 0; c < 40 && t_first < 0; c++) begin
      @(negedge clk);
      if (m_valid) t_first = cyc;
      else if (s_ready || core_write || !busy) wait_bad = 1'b1;
    end
    check("wait_ctrl", wait_bad, 0);
    check("first_m_valid_cycle", t_first, t_last + 2 + LAT);
    if (t_first < 0) return;

    bin = 0; hold = 0; stalled = 1'b0; guard = 0; prev = '0;
    while (bin < 8 && guard < 100) begin
      guard++;
      check("unload_valid_sready", {m_valid, s_ready}, 2'b10);
      check("unload_last", m_last, (bin == 7));
      if (stalled) check("stall_stable", {m_last, m_re, m_im}, prev);
      yr[16*bin +: 16] = m_re;
      yi[16*bin +: 16] = m_im;
      prev = {m_last, m_re, m_im};
      if (bin == bp_bin && hold < bp_len) begin
        m_ready = 1'b0;
        hold++;
      end else begin
        m_ready = 1'b1;
      end
      stalled = !m_ready;
      if (m_ready) bin++;
      @(negedge clk);
    end
    check("unload_count", bin, 8);
    m_ready = 1'b1;
    s_valid = 1'b0;
    check("post_frame_ctrl", {s_ready, m_valid, busy, core_write}, 4'b1000);
    frames++;
  endtask

  function automatic logic [127:0] rnd_frame();
    logic [127:0] f;
    logic [14:0]  mag;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      mag = 15'($urandom_range(0, 1024));
      f[16*k +: 16] = {1'($urandom_range(0, 1)), mag};
    end
    return f;
  endfunction

  task automatic cmp_model(input string tag, input logic [127:0] xr, input logic [127:0] xi,
                           input logic [127:0] yr, input logic [127:0] yi);
    logic [127:0] er, ei;
    dft(xr, xi, er, ei);
    check({tag, "_re"}, yr, er);
    check({tag, "_im"}, yi, ei);
  endtask

  typedef struct {
    logic [127:0] xr, xi, er, ei;
    bit           gaps;
    int           bp_bin, bp_len;
  } vec_t;

  initial begin
    vec_t         vecs [5];
    logic [127:0] xr, xi, yr, yi;
    bit           bad;

    // impulse at n=0 -> flat spectrum
    vecs[0].xr = 128'h0100;             vecs[0].xi = '0;
    vecs[0].er = {8{16'h0100}};         vecs[0].ei = '0;
    vecs[0].gaps = 1'b0; vecs[0].bp_bin = 8; vecs[0].bp_len = 0;
    // DC -> bin0 = 8.0
    vecs[1].xr = {8{16'h0100}};         vecs[1].xi = '0;
    vecs[1].er = 128'h0800;             vecs[1].ei = '0;
    vecs[1].gaps = 1'b0; vecs[1].bp_bin = 8; vecs[1].bp_len = 0;
    // impulse at n=4 -> alternating sign, fed with input gaps
    vecs[2].xr = 128'h0100 << 64;       vecs[2].xi = '0;
    vecs[2].er = {4{16'h8100, 16'h0100}}; vecs[2].ei = '0;
    vecs[2].gaps = 1'b1; vecs[2].bp_bin = 8; vecs[2].bp_len = 0;
    // impulse at n=2 -> e^{-j*pi*k/2}, with 3 stall cycles at bin 2
    vecs[3].xr = 128'h0100 << 32;       vecs[3].xi = '0;
    vecs[3].er = {2{16'h0000, 16'h8100, 16'h0000, 16'h0100}};
    vecs[3].ei = {2{16'h0100, 16'h0000, 16'h8100, 16'h0000}};
    vecs[3].gaps = 1'b0; vecs[3].bp_bin = 2; vecs[3].bp_len = 3;
    // all negative zero in -> zero magnitude out
    vecs[4].xr = {8{16'h8000}};         vecs[4].xi = {8{16'h8000}};
    vecs[4].er = '0;                    vecs[4].ei = '0;
    vecs[4].gaps = 1'b1; vecs[4].bp_bin = 7; vecs[4].bp_len = 2;

    rst_n = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {s_ready, m_valid, m_last, core_write, core_start, busy}, 6'b100000);
    check("reset_m_data", {m_re, m_im}, 0);
    check("reset_core_in", {core_in_r, core_in_i}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven frames
    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].xr, vecs[i].xi, vecs[i].gaps, vecs[i].bp_bin, vecs[i].bp_len, yr, yi);
      for (int k = 0; k < 8; k++) begin
        check_bin($sformatf("vec%0d_re%0d", i, k), yr[16*k +: 16], vecs[i].er[16*k +: 16]);
        check_bin($sformatf("vec%0d_im%0d", i, k), yi[16*k +: 16], vecs[i].ei[16*k +: 16]);
      end
    end

    // partial frame waits indefinitely, then reset while in LOAD
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_re = 16'($urandom); s_im = 16'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!s_ready || busy || core_write || m_valid) bad = 1'b1;
    end
    check("partial_frame_idle", bad, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frames = 0;

    // reset in the middle of WAIT abandons the frame
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_re = 16'($urandom); s_im = 16'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("midwait_fire", core_write, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_midwait_ctrl", {s_ready, m_valid, m_last, busy, core_write, core_start}, 6'b100000);
    check("reset_midwait_m_data", {m_re, m_im}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frames = 0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (!s_ready || m_valid || busy || core_write) bad = 1'b1;
    end
    check("post_reset_idle", bad, 0);
    xr = rnd_frame(); xi = rnd_frame();
    run_frame(xr, xi, 1'b0, 8, 0, yr, yi);
    cmp_model("after_reset", xr, xi, yr, yi);

    // randomized frames against the DFT reference
    for (int f = 0; f < 12; f++) begin
      xr = rnd_frame(); xi = rnd_frame();
      run_frame(xr, xi, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3), yr, yi);
      cmp_model($sformatf("rand%0d", f), xr, xi, yr, yi);
    end

`ifdef FFT8_FRAME_CNT_EN
    check("frames_done", frames_done, frames);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
